// File: rtl/mpsoc_wb_uart_tx_param.sv
// -----------------------------------------------------------------------------
// mpsoc_wb_uart_tx_param
//
// Parametrised UART transmitter: a first-word-fall-through TX FIFO feeding a
// frame serialiser (start, 5..DATA_W data bits LSB first, optional parity,
// 1 / 1.5 / 2 stop bits). All serialiser activity advances only on `enable`
// ticks (OVERSAMPLE ticks per bit). FIFO pushes and flushes act on every clk.
//
// Optional feature macro: UART_TX_CTS_EN adds input cts_n; a new frame is only
// started while cts_n is low. A frame already started always completes.
//
// Parameters
//   DATA_W      maximum word length (5..9)
//   FIFO_DEPTH  TX FIFO entries (power of 2, >= 2)
//   OVERSAMPLE  enable ticks per bit (even, >= 4)
//   CNT_W       width of tf_count
//
// Ports
//   clk, wb_rst_i           clock, asynchronous active-high reset
//   enable                  baud tick, one clk wide
//   cts_n                   clear-to-send, active low (UART_TX_CTS_EN only)
//   word_len                data bits per frame (clamped to 5..DATA_W)
//   parity_en/even/stick    parity configuration
//   stop2                   two stop bits (1.5 when word length is 5)
//   brk                     force the pin low
//   tf_push, tf_data        FIFO write
//   tx_reset                synchronous FIFO flush
//   ovr_clr                 clear tf_overrun
//   stx_pad_o               serial output
//   tstate                  FSM state (debug / status)
//   tf_count, tf_full       FIFO occupancy
//   tf_overrun              sticky: a push was dropped
//   tx_empty                FIFO empty and FSM idle
//
// Push handshake: tf_push is a one-cycle write strobe with no back-pressure;
// the writer may look at tf_full beforehand. A push is taken when the FIFO has
// room or a pop happens in the same cycle; otherwise it is dropped and
// tf_overrun is set.
// -----------------------------------------------------------------------------
module mpsoc_wb_uart_tx_param #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int OVERSAMPLE = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              wb_rst_i,
    input  logic              enable,
`ifdef UART_TX_CTS_EN
    input  logic              cts_n,
`endif
    input  logic [3:0]        word_len,
    input  logic              parity_en,
    input  logic              parity_even,
    input  logic              parity_stick,
    input  logic              stop2,
    input  logic              brk,
    input  logic              tf_push,
    input  logic [DATA_W-1:0] tf_data,
    input  logic              tx_reset,
    input  logic              ovr_clr,
    output logic              stx_pad_o,
    output logic [2:0]        tstate,
    output logic [CNT_W-1:0]  tf_count,
    output logic              tf_full,
    output logic              tf_overrun,
    output logic              tx_empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int TCK_W = $clog2(2 * OVERSAMPLE);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_PARITY = 3'd4,
        S_STOP   = 3'd5
    } tx_state_t;

    // ---------------------------------------------------------------- FIFO
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] head;
    logic              tf_pop;
    logic              push_ok;
    logic              cts_ok;

    tx_state_t         state_q, state_d;

    assign head    = mem[rd_ptr];
    assign tf_pop  = (state_q == S_LOAD) && enable && (tf_count != '0);
    assign push_ok = tf_push && ((tf_count < CNT_W'(FIFO_DEPTH)) || tf_pop);
    assign tf_full = (tf_count == CNT_W'(FIFO_DEPTH));

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            tf_count   <= '0;
            tf_overrun <= 1'b0;
        end else if (tx_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            tf_count   <= '0;
            tf_overrun <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (tf_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, tf_pop})
                2'b10:   tf_count <= tf_count + 1'b1;
                2'b01:   tf_count <= tf_count - 1'b1;
                default: tf_count <= tf_count;
            endcase
            // A dropped push in the same cycle as ovr_clr keeps the flag set
            // so the loss is never silently forgotten.
            if (tf_push && !push_ok) tf_overrun <= 1'b1;
            else if (ovr_clr)        tf_overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !tx_reset) mem[wr_ptr] <= tf_data;
    end

`ifdef UART_TX_CTS_EN
    assign cts_ok = ~cts_n;
`else
    assign cts_ok = 1'b1;
`endif

    // ------------------------------------------------- frame configuration
    logic [3:0]       wl_clamp;
    logic             data_xor;
    logic             par_calc;
    logic [TCK_W-1:0] stop_calc;

    always_comb begin
        wl_clamp = word_len;
        if (word_len < 4'd5)               wl_clamp = 4'd5;
        else if (word_len > 4'(DATA_W))    wl_clamp = 4'(DATA_W);
    end

    always_comb begin
        data_xor = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (4'(i) < wl_clamp) data_xor = data_xor ^ head[i];
        end
    end

    always_comb begin
        if (parity_stick)     par_calc = ~parity_even;
        else if (parity_even) par_calc = data_xor;
        else                  par_calc = ~data_xor;
    end

    // Stop duration is stored as "last tick index" so 2*OVERSAMPLE fits in TCK_W.
    always_comb begin
        if (!stop2)                 stop_calc = TCK_W'(OVERSAMPLE - 1);
        else if (wl_clamp == 4'd5)  stop_calc = TCK_W'(3 * OVERSAMPLE / 2 - 1);
        else                        stop_calc = TCK_W'(2 * OVERSAMPLE - 1);
    end

    // ------------------------------------------------------------- serialiser
    logic [TCK_W-1:0]  tick_q, tick_d;
    logic [3:0]        bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              line_q, line_d;
    logic [3:0]        wl_q, wl_d;
    logic              pen_q, pen_d;
    logic              par_q, par_d;
    logic [TCK_W-1:0]  stop_last_q, stop_last_d;
    logic              bit_end;

    assign bit_end = (tick_q == TCK_W'(OVERSAMPLE - 1));

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= S_IDLE;
            tick_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            line_q      <= 1'b1;
            wl_q        <= 4'd5;
            pen_q       <= 1'b0;
            par_q       <= 1'b0;
            stop_last_q <= '0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            line_q      <= line_d;
            wl_q        <= wl_d;
            pen_q       <= pen_d;
            par_q       <= par_d;
            stop_last_q <= stop_last_d;
        end
    end

    // The line register is loaded with the level of the state being entered,
    // so the pin changes in the clk right after the tick causing the change.
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        line_d      = line_q;
        wl_d        = wl_q;
        pen_d       = pen_q;
        par_d       = par_q;
        stop_last_d = stop_last_q;
        if (enable) begin
            case (state_q)
                S_IDLE: begin
                    line_d = 1'b1;
                    if ((tf_count != '0) && cts_ok) state_d = S_LOAD;
                end
                S_LOAD: begin
                    // A flush between IDLE and LOAD leaves nothing to send.
                    if (tf_count != '0) begin
                        shift_d     = head;
                        wl_d        = wl_clamp;
                        pen_d       = parity_en;
                        par_d       = par_calc;
                        stop_last_d = stop_calc;
                        tick_d      = '0;
                        bit_d       = '0;
                        line_d      = 1'b0;
                        state_d     = S_START;
                    end else begin
                        state_d     = S_IDLE;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        tick_d  = '0;
                        line_d  = shift_q[0];
                        state_d = S_DATA;
                    end else begin
                        tick_d  = tick_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        tick_d = '0;
                        if (bit_q == wl_q - 4'd1) begin
                            if (pen_q) begin
                                line_d  = par_q;
                                state_d = S_PARITY;
                            end else begin
                                line_d  = 1'b1;
                                state_d = S_STOP;
                            end
                        end else begin
                            bit_d   = bit_q + 4'd1;
                            shift_d = shift_q >> 1;
                            line_d  = shift_q[1];
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        tick_d  = '0;
                        line_d  = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        tick_d  = tick_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (tick_q == stop_last_q) begin
                        tick_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        tick_d  = tick_q + 1'b1;
                    end
                end
                default: begin
                    tick_d  = '0;
                    bit_d   = '0;
                    line_d  = 1'b1;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign stx_pad_o = brk ? 1'b0 : line_q;
    assign tstate    = state_q;
    assign tx_empty  = (tf_count == '0) && (state_q == S_IDLE);

endmodule

// File: tb/tb_mpsoc_wb_uart_tx_param.sv
// -----------------------------------------------------------------------------
// tb_mpsoc_wb_uart_tx_param
//
// Frames are described by a reference model as a list of line levels plus a
// stop length; a receiver process decodes the pin on enable ticks and checks
// each frame against the head of the expected queue.
// Expected record layout: [15:0] line levels (start first), [19:16] number of
// levels, [27:20] stop ticks, [28] another frame follows back-to-back.
// -----------------------------------------------------------------------------
module tb_mpsoc_wb_uart_tx_param;

    localparam int DATA_W     = 9;
    localparam int FIFO_DEPTH = 16;
    localparam int OVERSAMPLE = 16;
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int W          = 32;

    logic              clk = 1'b0;
    logic              wb_rst_i;
    logic              enable;
`ifdef UART_TX_CTS_EN
    logic              cts_n;
`endif
    logic [3:0]        word_len;
    logic              parity_en;
    logic              parity_even;
    logic              parity_stick;
    logic              stop2;
    logic              brk;
    logic              tf_push;
    logic [DATA_W-1:0] tf_data;
    logic              tx_reset;
    logic              ovr_clr;
    logic              stx_pad_o;
    logic [2:0]        tstate;
    logic [CNT_W-1:0]  tf_count;
    logic              tf_full;
    logic              tf_overrun;
    logic              tx_empty;

    mpsoc_wb_uart_tx_param #(
        .DATA_W    (DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH),
        .OVERSAMPLE(OVERSAMPLE),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .wb_rst_i    (wb_rst_i),
        .enable      (enable),
`ifdef UART_TX_CTS_EN
        .cts_n       (cts_n),
`endif
        .word_len    (word_len),
        .parity_en   (parity_en),
        .parity_even (parity_even),
        .parity_stick(parity_stick),
        .stop2       (stop2),
        .brk         (brk),
        .tf_push     (tf_push),
        .tf_data     (tf_data),
        .tx_reset    (tx_reset),
        .ovr_clr     (ovr_clr),
        .stx_pad_o   (stx_pad_o),
        .tstate      (tstate),
        .tf_count    (tf_count),
        .tf_full     (tf_full),
        .tf_overrun  (tf_overrun),
        .tx_empty    (tx_empty)
    );

    // ------------------------------------------------ clock / enable
    always #5 clk = ~clk;

    int en_mode = 0;   // 0 off, 1 every clk, 2 random
    initial begin
        enable = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (en_mode)
                0:       enable = 1'b0;
                1:       enable = 1'b1;
                default: enable = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // ------------------------------------------------ scoreboard state
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int mcount = 0;
    int cfg_wl = 8;
    logic cfg_pen = 1'b0, cfg_even = 1'b0, cfg_stick = 1'b0, cfg_stop2 = 1'b0;
    logic [DATA_W-1:0] words[$];

    function automatic logic [W-1:0] make_frame(input logic [DATA_W-1:0] d, input logic b2b);
        int wl, ones, nb, stop;
        logic [15:0] bits;
        logic pb;
        wl = (cfg_wl < 5) ? 5 : ((cfg_wl > DATA_W) ? DATA_W : cfg_wl);
        bits = '0;
        ones = 0;
        for (int i = 0; i < wl; i++) begin
            bits[i+1] = d[i];
            if (d[i]) ones++;
        end
        nb = 1 + wl;
        if (cfg_pen) begin
            if (cfg_stick)     pb = !cfg_even;
            else if (cfg_even) pb = (ones % 2 == 1);
            else               pb = (ones % 2 == 0);
            bits[nb] = pb;
            nb++;
        end
        if (!cfg_stop2)   stop = OVERSAMPLE;
        else if (wl == 5) stop = OVERSAMPLE * 3 / 2;
        else              stop = 2 * OVERSAMPLE;
        return {3'b000, b2b, 8'(stop), 4'(nb), bits};
    endfunction

    task automatic check1(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    // ------------------------------------------------ driver tasks
    task automatic set_cfg(input int wl, input logic pen, input logic even,
                           input logic stick, input logic s2);
        @(posedge clk);
        #1;
        cfg_wl = wl; cfg_pen = pen; cfg_even = even; cfg_stick = stick; cfg_stop2 = s2;
        word_len = 4'(wl); parity_en = pen; parity_even = even;
        parity_stick = stick; stop2 = s2;
    endtask

    task automatic push_word(input logic [DATA_W-1:0] d, input logic b2b, input logic want);
        @(posedge clk);
        #1;
        tf_push = 1'b1;
        tf_data = d;
        @(posedge clk);
        #1;
        tf_push = 1'b0;
        if (mcount < FIFO_DEPTH) begin
            if (want) exp_q.push_back(make_frame(d, b2b));
            mcount++;
        end
        check1("tf_count_after_push", int'(tf_count), mcount);
    endtask

    // Enable is stopped first, so the FIFO only fills; nothing drains.
    task automatic fill_words();
        int n;
        en_mode = 0;
        repeat (2) @(posedge clk);
        mcount = 0;
        n = words.size();
        for (int i = 0; i < n; i++)
            push_word(words[i], (i < n - 1) && (i < FIFO_DEPTH - 1), 1'b1);
    endtask

    task automatic wait_empty(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!tx_empty && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!tx_empty) begin
            errors++;
            $display("FAIL tx_empty_timeout: got 0 required 1 within %0d cycles", budget);
        end
    endtask

    task automatic get_tick(output logic v);
        do @(negedge clk); while (!enable);
        v = stx_pad_o;
    endtask

    // ------------------------------------------------ monitor / receiver
    initial begin : monitor
        logic v, first, unstable, have_prev, prev_b2b, known;
        logic [W-1:0] e;
        logic [15:0] obs;
        int run, prev_stop, nb;
        run = 0; have_prev = 1'b0; prev_b2b = 1'b0; prev_stop = 0;
        forever begin
            get_tick(v);
            if (v) begin
                run++;
            end else begin
                if (have_prev) begin
                    checks++;
                    if (prev_b2b ? (run != prev_stop + 2) : (run < prev_stop + 2)) begin
                        errors++;
                        $display("FAIL frame_gap: got %0d high ticks required %s%0d",
                                 run, prev_b2b ? "" : "at least ", prev_stop + 2);
                    end
                end
                known = (exp_q.size() != 0);
                checks++;
                if (known) begin
                    e = exp_q.pop_front();
                end else begin
                    errors++;
                    $display("FAIL unexpected_frame: got a start bit required none");
                    e = {3'b000, 1'b0, 8'd16, 4'd10, 16'h0000};
                end
                nb = int'(e[19:16]);
                obs = '0;
                unstable = 1'b0;
                first = 1'b0;
                for (int k = 0; k < nb; k++) begin
                    for (int s = 0; s < OVERSAMPLE; s++) begin
                        if (!(k == 0 && s == 0)) get_tick(v);
                        if (s == 0) first = v;
                        else if (v != first) unstable = 1'b1;
                        if (s == OVERSAMPLE / 2) obs[k] = v;
                    end
                end
                if (known) begin
                    checks++;
                    if (obs != e[15:0]) begin
                        errors++;
                        $display("FAIL frame_bits: got %h required %h (levels, start in bit 0)",
                                 obs, e[15:0]);
                    end
                    check1("bit_period_stable", int'(unstable), 0);
                end
                have_prev = 1'b1;
                prev_b2b  = e[28];
                prev_stop = int'(e[27:20]);
                run = 0;
            end
        end
    end

    // ------------------------------------------------ main sequence
    initial begin
        int nw, mode, tmo;
        wb_rst_i = 1'b1;
`ifdef UART_TX_CTS_EN
        cts_n = 1'b0;
`endif
        word_len = 4'd8; parity_en = 1'b0; parity_even = 1'b0; parity_stick = 1'b0;
        stop2 = 1'b0; brk = 1'b0; tf_push = 1'b0; tf_data = '0; tx_reset = 1'b0;
        ovr_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check1("rst_tstate", int'(tstate), 0);
        check1("rst_stx", int'(stx_pad_o), 1);
        check1("rst_count", int'(tf_count), 0);
        check1("rst_full", int'(tf_full), 0);
        check1("rst_overrun", int'(tf_overrun), 0);
        check1("rst_tx_empty", int'(tx_empty), 1);
        wb_rst_i = 1'b0;
        repeat (2) @(posedge clk);

        // 8N1, 0xA5
        set_cfg(8, 1'b0, 1'b0, 1'b0, 1'b0);
        words = {9'h0A5};
        fill_words();
        en_mode = 1;
        wait_empty(8000);

        // 7E1 and 7-bit stick parity, 0x03
        set_cfg(7, 1'b1, 1'b1, 1'b0, 1'b0);
        words = {9'h003};
        fill_words();
        en_mode = 1;
        wait_empty(8000);
        set_cfg(7, 1'b1, 1'b0, 1'b1, 1'b0);
        words = {9'h003};
        fill_words();
        en_mode = 2;
        wait_empty(8000);

        // 5 bits, 1.5 stop, back-to-back
        set_cfg(5, 1'b0, 1'b0, 1'b0, 1'b1);
        words = {9'h015, 9'h00A};
        fill_words();
        en_mode = 2;
        wait_empty(8000);

        // randomized bursts, including clamped word lengths
        for (int b = 0; b < 8; b++) begin
            set_cfg($urandom_range(3, 12), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            words.delete();
            nw = $urandom_range(1, 4);
            for (int i = 0; i < nw; i++) words.push_back(DATA_W'($urandom));
            fill_words();
            mode = $urandom_range(1, 2);
            en_mode = mode;
            wait_empty(12000);
        end

        // overrun: 17 pushes into 16 entries, the last one is dropped
        set_cfg(8, 1'b0, 1'b0, 1'b0, 1'b0);
        words.delete();
        for (int i = 0; i < FIFO_DEPTH + 1; i++) words.push_back(DATA_W'($urandom_range(0, 255)));
        fill_words();
        check1("ovr_count", int'(tf_count), FIFO_DEPTH);
        check1("ovr_full", int'(tf_full), 1);
        check1("ovr_flag", int'(tf_overrun), 1);
        @(posedge clk); #1; ovr_clr = 1'b1;
        @(posedge clk); #1; ovr_clr = 1'b0;
        check1("ovr_cleared", int'(tf_overrun), 0);
        check1("ovr_count_kept", int'(tf_count), FIFO_DEPTH);
        en_mode = 1;
        wait_empty(12000);

        // 9-bit word then flush during its data bits
        set_cfg(9, 1'b0, 1'b0, 1'b0, 1'b0);
        en_mode = 0;
        repeat (2) @(posedge clk);
        mcount = 0;
        push_word(9'h1FF, 1'b0, 1'b1);
        push_word(9'h055, 1'b0, 1'b0);
        en_mode = 1;
        tmo = 0;
        @(negedge clk);
        while (tstate != 3'd3 && tmo < 200) begin
            @(negedge clk);
            tmo++;
        end
        check1("reach_data_state", int'(tstate), 3);
        repeat (40) @(posedge clk);
        #1; tx_reset = 1'b1;
        @(posedge clk); #1; tx_reset = 1'b0;
        check1("flush_count", int'(tf_count), 0);
        wait_empty(8000);
        repeat (300) @(posedge clk);

        // break forces the pin low while idle
        en_mode = 0;
        repeat (2) @(posedge clk);
        #1; brk = 1'b1;
        @(posedge clk); #1;
        check1("brk_low", int'(stx_pad_o), 0);
        brk = 1'b0;
        @(posedge clk); #1;
        check1("brk_release", int'(stx_pad_o), 1);

        check1("exp_queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
